// File: rtl/alu_exec_if.sv
`default_nettype none
// ============================================================================
// alu_exec_if : operand/instruction request and result handshake bundle
// Rev 1.0
// ============================================================================
interface alu_exec_if #(
  parameter int WIDTH = 16,
  parameter int INS_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] RA;
  logic [WIDTH-1:0] RB;
  logic [INS_W-1:0] ins;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] RA_OUT;
  logic [WIDTH-1:0] RB_OUT;
  logic             carry;
  logic             zero;

  modport master (
    output in_valid, RA, RB, ins, out_ready,
    input  in_ready, out_valid, RA_OUT, RB_OUT, carry, zero
  );

  modport slave (
    input  in_valid, RA, RB, ins, out_ready,
    output in_ready, out_valid, RA_OUT, RB_OUT, carry, zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// alu_exec_unit : registered, handshaked 8-op ALU with a 1-bit/cycle SHR
// Rev 1.0
// ============================================================================
module alu_exec_unit #(
  parameter int WIDTH     = 16,
  parameter int INS_W     = 16,
  parameter int SEL_LSB   = 0,
  parameter int SHAMT_LSB = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_exec_if.slave  bus
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_EXCH = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_q;
  logic [2:0]       op_q;
  logic [SW-1:0]    shamt_q;
  logic [SW-1:0]    cnt;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] shifted;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] ra_out_q;
  logic [WIDTH-1:0] rb_out_q;
  logic             carry_q;
  logic             zero_q;

  logic [WIDTH-1:0] res_a;
  logic [WIDTH-1:0] res_b;
  logic             res_c;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.RA_OUT    = ra_out_q;
  assign bus.RB_OUT    = rb_out_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;

  assign shifted = work >> 1;

  // Single-cycle ops; SHR only lands here when its shift amount is zero.
  always_comb begin
    res_a = ra_q;
    res_b = rb_q;
    res_c = 1'b0;
    case (op_q)
      OP_ADD:  {res_c, res_a} = {1'b0, ra_q} + {1'b0, rb_q};
      OP_SUB:  begin
        res_a = ra_q - rb_q;
        res_c = (ra_q < rb_q);
      end
      OP_OR:   res_a = ra_q | rb_q;
      OP_AND:  res_a = ra_q & rb_q;
      OP_XOR:  res_a = ra_q ^ rb_q;
      OP_SHR:  res_a = ra_q;
      OP_MOV:  res_b = ra_q;
      OP_EXCH: begin
        res_a = rb_q;
        res_b = ra_q;
      end
      default: res_a = ra_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ra_q        <= '0;
      rb_q        <= '0;
      op_q        <= '0;
      shamt_q     <= '0;
      cnt         <= '0;
      work        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ra_out_q    <= '0;
      rb_out_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            ra_q       <= bus.RA;
            rb_q       <= bus.RB;
            op_q       <= bus.ins[SEL_LSB +: 3];
            shamt_q    <= bus.ins[SHAMT_LSB +: SW];
            in_ready_q <= 1'b0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (op_q == OP_SHR && shamt_q != '0) begin
            work  <= ra_q;
            cnt   <= shamt_q;
            state <= SHIFT;
          end else begin
            ra_out_q    <= res_a;
            rb_out_q    <= res_b;
            carry_q     <= res_c;
            zero_q      <= (res_a == '0);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        SHIFT: begin
          // Visible outputs keep the previous result until the last shift lands.
          work <= shifted;
          cnt  <= cnt - SW'(1);
          if (cnt == SW'(1)) begin
            ra_out_q    <= shifted;
            rb_out_q    <= rb_q;
            carry_q     <= work[0];
            zero_q      <= (shifted == '0);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
